// File: rtl/leading_bits_inserter.sv
// Multi-cycle leading-bit inserter: logical right shift with configurable fill,
// one binary-weighted stage per cycle, plus a sticky OR of every bit shifted out.
module leading_bits_inserter #(
  parameter int unsigned INPUT_VECTOR_WIDTH = 64,
  parameter int unsigned COUNT_VECTOR_WIDTH = $clog2(INPUT_VECTOR_WIDTH),
  parameter logic        BIT_TO_INSERT      = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          input_valid,
  output logic                          input_ready,
  input  logic [INPUT_VECTOR_WIDTH-1:0] input_vector,
  input  logic [COUNT_VECTOR_WIDTH-1:0] count_vector,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [INPUT_VECTOR_WIDTH-1:0] output_vector,
  output logic                          sticky_bit
);

  localparam int unsigned W  = INPUT_VECTOR_WIDTH;
  localparam int unsigned CW = COUNT_VECTOR_WIDTH;
  localparam logic [W-1:0] ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state, w_state;
  logic [CW-1:0]  r_stage, w_stage;
  logic [CW-1:0]  r_count, w_count;
  logic [W-1:0]   r_work, w_work;
  logic           r_sticky_acc, w_sticky_acc;
  logic [W-1:0]   r_out_vec, w_out_vec;
  logic           r_out_sticky, w_out_sticky;
  logic           r_out_valid, w_out_valid;
  logic           r_in_ready, w_in_ready;

  logic [W-1:0]   w_shifted;
  logic           w_lost;
  logic           w_stage_bit;
  logic [W-1:0]   w_step_vec;
  logic           w_step_sticky;

  // Shift right by amt, filling the vacated top positions with BIT_TO_INSERT.
  function automatic logic [W-1:0] shift_fill(input logic [W-1:0] v, input int unsigned amt);
    logic [W-1:0] fill_mask;
    fill_mask = ~(ONES >> amt);
    if (BIT_TO_INSERT) begin
      return (v >> amt) | fill_mask;
    end
    return v >> amt;
  endfunction

  // Mask of the amt least-significant positions, i.e. the bits a shift discards.
  function automatic logic [W-1:0] low_mask(input int unsigned amt);
    return ~(ONES << amt);
  endfunction

  // Stage k shifts by 2^k when captured count bit k is set.
  always_comb begin
    w_shifted   = r_work;
    w_lost      = 1'b0;
    w_stage_bit = 1'b0;
    for (int unsigned k = 0; k < CW; k++) begin
      if (r_stage == CW'(k)) begin
        w_shifted   = shift_fill(r_work, 32'(1) << k);
        w_lost      = |(r_work & low_mask(32'(1) << k));
        w_stage_bit = r_count[k];
      end
    end
    w_step_vec    = w_stage_bit ? w_shifted : r_work;
    w_step_sticky = r_sticky_acc | (w_stage_bit & w_lost);
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state      = r_state;
    w_stage      = r_stage;
    w_count      = r_count;
    w_work       = r_work;
    w_sticky_acc = r_sticky_acc;
    w_out_vec    = r_out_vec;
    w_out_sticky = r_out_sticky;
    w_out_valid  = r_out_valid;
    w_in_ready   = r_in_ready;

    case (r_state)
      S_IDLE: begin
        if (input_valid) begin
          w_state      = S_SHIFT;
          w_stage      = CW'(CW - 1);
          w_count      = count_vector;
          w_work       = input_vector;
          w_sticky_acc = 1'b0;
          w_in_ready   = 1'b0;
        end
      end
      S_SHIFT: begin
        w_work       = w_step_vec;
        w_sticky_acc = w_step_sticky;
        if (r_stage == '0) begin
          w_state      = S_DONE;
          w_out_vec    = w_step_vec;
          w_out_sticky = w_step_sticky;
          w_out_valid  = 1'b1;
        end else begin
          w_stage = r_stage - CW'(1);
        end
      end
      S_DONE: begin
        if (output_ready) begin
          w_state      = S_IDLE;
          w_out_vec    = '0;
          w_out_sticky = 1'b0;
          w_out_valid  = 1'b0;
          w_in_ready   = 1'b1;
        end
      end
      default: begin
        w_state      = S_IDLE;
        w_stage      = '0;
        w_out_vec    = '0;
        w_out_sticky = 1'b0;
        w_out_valid  = 1'b0;
        w_in_ready   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_stage      <= '0;
      r_count      <= '0;
      r_work       <= '0;
      r_sticky_acc <= 1'b0;
      r_out_vec    <= '0;
      r_out_sticky <= 1'b0;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_stage      <= w_stage;
      r_count      <= w_count;
      r_work       <= w_work;
      r_sticky_acc <= w_sticky_acc;
      r_out_vec    <= w_out_vec;
      r_out_sticky <= w_out_sticky;
      r_out_valid  <= w_out_valid;
      r_in_ready   <= w_in_ready;
    end
  end

  assign input_ready   = r_in_ready;
  assign output_valid  = r_out_valid;
  assign output_vector = r_out_vec;
  assign sticky_bit    = r_out_sticky;

endmodule

// File: tb/tb_leading_bits_inserter.sv
// Bench for leading_bits_inserter: fill-0 and fill-1 instances share stimulus and
// are checked every cycle against a transaction-level model plus literal vectors.
module tb_leading_bits_inserter;

  localparam int unsigned W  = 64;
  localparam int unsigned CW = 6;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          input_valid = 1'b0;
  logic [W-1:0]  input_vector = '0;
  logic [CW-1:0] count_vector = '0;
  logic          output_ready = 1'b0;

  logic          in_ready0, out_valid0, sticky0;
  logic [W-1:0]  out_vec0;
  logic          in_ready1, out_valid1, sticky1;
  logic [W-1:0]  out_vec1;

  int n_checks = 0;
  int n_errors = 0;

  leading_bits_inserter #(.INPUT_VECTOR_WIDTH(W), .COUNT_VECTOR_WIDTH(CW), .BIT_TO_INSERT(1'b0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .input_valid(input_valid), .input_ready(in_ready0),
    .input_vector(input_vector), .count_vector(count_vector), .output_valid(out_valid0),
    .output_ready(output_ready), .output_vector(out_vec0), .sticky_bit(sticky0));

  leading_bits_inserter #(.INPUT_VECTOR_WIDTH(W), .COUNT_VECTOR_WIDTH(CW), .BIT_TO_INSERT(1'b1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .input_valid(input_valid), .input_ready(in_ready1),
    .input_vector(input_vector), .count_vector(count_vector), .output_valid(out_valid1),
    .output_ready(output_ready), .output_vector(out_vec1), .sticky_bit(sticky1));

  always #5 clock = ~clock;

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bit i of the result is input bit i+cnt, or the fill bit past the top.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int cnt, input logic fill);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = (i + cnt < int'(W)) ? v[i + cnt] : fill;
    return r;
  endfunction

  function automatic logic ref_sticky(input logic [W-1:0] v, input int cnt);
    logic s;
    s = 1'b0;
    for (int i = 0; i < cnt; i++) s = s | v[i];
    return s;
  endfunction

  // Transaction model: 0 idle, 1 busy counting down the latency, 2 result held.
  int           m_phase = 0;
  int           m_left = 0;
  logic [W-1:0] m_vec0 = '0, m_vec1 = '0;
  logic         m_st0 = 1'b0, m_st1 = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0;
      m_left  = 0;
    end else begin
      case (m_phase)
        0: if (input_valid) begin
          m_vec0  = ref_shift(input_vector, int'(count_vector), 1'b0);
          m_vec1  = ref_shift(input_vector, int'(count_vector), 1'b1);
          m_st0   = ref_sticky(input_vector, int'(count_vector));
          m_st1   = m_st0;
          m_left  = int'(CW);
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (output_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    logic mv;
    mv = (m_phase == 2);
    check_int("cyc_in_ready0", int'(in_ready0), int'(m_phase == 0));
    check_int("cyc_in_ready1", int'(in_ready1), int'(m_phase == 0));
    check_int("cyc_valid0", int'(out_valid0), int'(mv));
    check_int("cyc_valid1", int'(out_valid1), int'(mv));
    check_vec("cyc_vec0", out_vec0, mv ? m_vec0 : '0);
    check_vec("cyc_vec1", out_vec1, mv ? m_vec1 : '0);
    check_int("cyc_sticky0", int'(sticky0), int'(mv & m_st0));
    check_int("cyc_sticky1", int'(sticky1), int'(mv & m_st1));
  end

  task automatic run_op(input logic [W-1:0] vec, input logic [CW-1:0] cnt,
                        input logic [W-1:0] e0, input logic s0,
                        input logic [W-1:0] e1, input logic s1, input int hold);
    int lat;
    @(negedge clock);
    input_vector = vec;
    count_vector = cnt;
    input_valid  = 1'b1;
    output_ready = 1'b0;
    @(posedge clock);
    #1;
    input_valid  = 1'b0;
    input_vector = ~vec;
    count_vector = ~cnt;
    lat = 0;
    while (lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
      if (out_valid0) break;
    end
    check_int("latency", lat, 6);
    check_vec("lit_vec0", out_vec0, e0);
    check_int("lit_sticky0", int'(sticky0), int'(s0));
    check_vec("lit_vec1", out_vec1, e1);
    check_int("lit_sticky1", int'(sticky1), int'(s1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      input_valid  = 1'b1;
      input_vector = 64'h5555_AAAA_5555_AAAA;
      count_vector = 6'd1;
      @(posedge clock);
      #1;
      check_vec("hold_vec0", out_vec0, e0);
      check_vec("hold_vec1", out_vec1, e1);
      check_int("hold_valid", int'(out_valid0), 1);
      check_int("hold_in_ready", int'(in_ready0), 0);
    end
    @(negedge clock);
    input_valid  = 1'b0;
    output_ready = 1'b1;
    @(posedge clock);
    #1;
    output_ready = 1'b0;
    check_int("post_valid", int'(out_valid0), 0);
    check_int("post_in_ready", int'(in_ready0), 1);
    check_vec("post_vec", out_vec0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    #1;
    check_int("rst_in_ready", int'(in_ready0), 1);
    check_int("rst_valid", int'(out_valid0), 0);
    check_vec("rst_vec", out_vec1, '0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(64'h8000_0000_0000_0000, 6'd4,  64'h0800_0000_0000_0000, 1'b0, 64'hF800_0000_0000_0000, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'h0000_0000_0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    run_op(64'h0,                   6'd8,  64'h0,                   1'b0, 64'hFF00_0000_0000_0000, 1'b0, 0);
    run_op(64'h0000_0000_0000_00A5, 6'd0,  64'h0000_0000_0000_00A5, 1'b0, 64'h0000_0000_0000_00A5, 1'b0, 0);
    run_op(64'h0123_4567_89AB_CDEF, 6'd12, 64'h0000_1234_5678_9ABC, 1'b1, 64'hFFF0_1234_5678_9ABC, 1'b1, 10);
    run_op(64'h8000_0000_0000_0001, 6'd32, 64'h0000_0000_8000_0000, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1, 0);

    // Abort an operation while stage 3 is being worked on.
    @(negedge clock);
    input_vector = 64'hDEAD_BEEF_0000_FFFF;
    count_vector = 6'd17;
    input_valid  = 1'b1;
    @(posedge clock);
    #1;
    input_valid = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check_int("abort_valid", int'(out_valid0), 0);
    check_int("abort_in_ready", int'(in_ready0), 1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check_int("abort_no_result", int'(out_valid0 | out_valid1), 0);
      check_int("abort_ready_held", int'(in_ready0), 1);
    end

    run_op(64'h8000_0000_0000_0000, 6'd4,  64'h0800_0000_0000_0000, 1'b0, 64'hF800_0000_0000_0000, 1'b0, 0);

    repeat (3) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
